// File: rtl/regfile_wport_sched_if.sv
// regfile_wport_sched_if: WB/LU write requests, LU issue, ID sources, and register-file write/hazard/hold/error outputs
interface regfile_wport_sched_if;
  logic wb_valid;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  logic lu_valid;
  logic [4:0] lu_addr;
  logic [31:0] lu_data;
  logic lu_ready;
  logic issue_valid;
  logic [4:0] issue_rd;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic [4:0] id_rd_addr;
  logic hazard_stall;
  logic pipe_hold;
  logic reg_write;
  logic [4:0] wt_addr;
  logic [31:0] wt_data;
  logic protocol_err;
  modport slave (
    input wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    input issue_valid, issue_rd, id_rs1_addr, id_rs2_addr, id_rd_addr,
    output lu_ready, hazard_stall, pipe_hold, reg_write, wt_addr, wt_data, protocol_err
  );
  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    output issue_valid, issue_rd, id_rs1_addr, id_rs2_addr, id_rd_addr,
    input lu_ready, hazard_stall, pipe_hold, reg_write, wt_addr, wt_data, protocol_err
  );
endinterface

// File: rtl/regfile_wport_sched.sv
// regfile_wport_sched: WB-priority register-file write port mux with LU scoreboard, hazard stall and starvation hold (ports: clk, rst, bus slave)
module regfile_wport_sched #(
  parameter int MAX_WAIT = 4,
  parameter bit BYPASS_CLEAR = 1
) (
  input logic clk,
  input logic rst,
  regfile_wport_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [3:0] wait_cnt, cnt_n, cnt_inc;
  logic [31:0] busy, set_v, clr_v, busy_eff;
  logic hs, denied, err, err_n;
  assign hs = !bus.wb_valid && bus.lu_valid;
  assign denied = bus.wb_valid && bus.lu_valid;
  assign bus.lu_ready = hs;
  assign bus.wt_addr = bus.wb_valid ? bus.wb_addr : bus.lu_valid ? bus.lu_addr : 5'd0;
  assign bus.wt_data = bus.wb_valid ? bus.wb_data : bus.lu_valid ? bus.lu_data : 32'd0;
  assign bus.reg_write = bus.wb_valid ? bus.wb_addr != 5'd0 : hs && bus.lu_addr != 5'd0;
  assign set_v = (bus.issue_valid && bus.issue_rd != 5'd0) ? 32'd1 << bus.issue_rd : 32'd0;
  assign clr_v = hs ? 32'd1 << bus.lu_addr : 32'd0;
  // register file writes on negedge, so ID already sees a value retiring this cycle
  assign busy_eff = BYPASS_CLEAR ? busy & ~clr_v : busy;
  assign bus.hazard_stall = busy_eff[bus.id_rs1_addr] || busy_eff[bus.id_rs2_addr] || busy_eff[bus.id_rd_addr];
  assign bus.pipe_hold = state == HOLD;
  assign bus.protocol_err = err;
  assign cnt_inc = wait_cnt + 4'd1;
  always_comb begin
    state_n = !denied ? IDLE : (state == HOLD || cnt_inc == 4'(MAX_WAIT)) ? HOLD : WAIT;
    cnt_n = !denied ? 4'd0 : state == HOLD ? wait_cnt : cnt_inc;
    err_n = err
      || (bus.wb_valid && state == HOLD)
      || ((set_v & busy & ~clr_v) != 32'd0)
      || (hs && bus.lu_addr != 5'd0 && !busy[bus.lu_addr]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= 4'd0;
      busy <= 32'd0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= cnt_n;
      busy <= ((busy & ~clr_v) | set_v) & ~32'd1;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_regfile_wport_sched.sv
// tb_regfile_wport_sched: randomized and directed scoreboard bench against a behavioural write-port model
module tb_regfile_wport_sched;
  localparam int MW = 4;
  localparam bit BP = 1;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  regfile_wport_sched_if bus();
  regfile_wport_sched #(.MAX_WAIT(MW), .BYPASS_CLEAR(BP)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic lu_ready;
    logic hazard;
    logic hold;
    logic rw;
    logic [4:0] wa;
    logic [31:0] wd;
    logic err;
  } exp_t;
  exp_t q[$];
  bit m_busy[32];
  int m_run = 0;
  bit m_err = 0;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("lu_ready", 32'(bus.lu_ready), 32'(e.lu_ready));
      chk("hazard_stall", 32'(bus.hazard_stall), 32'(e.hazard));
      chk("pipe_hold", 32'(bus.pipe_hold), 32'(e.hold));
      chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
      chk("wt_addr", 32'(bus.wt_addr), 32'(e.wa));
      chk("wt_data", bus.wt_data, e.wd);
      chk("protocol_err", 32'(bus.protocol_err), 32'(e.err));
    end
  end
  function automatic bit haz(input logic [4:0] x, input bit hs, input logic [4:0] la);
    return x != 0 && m_busy[x] && !(BP && hs && la == x);
  endfunction
  task automatic step(input bit r, input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ir,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    exp_t e;
    bit hs, hold;
    rst = r;
    bus.wb_valid = wv; bus.wb_addr = wa; bus.wb_data = wd;
    bus.lu_valid = lv; bus.lu_addr = la; bus.lu_data = ld;
    bus.issue_valid = iv; bus.issue_rd = ir;
    bus.id_rs1_addr = s1; bus.id_rs2_addr = s2; bus.id_rd_addr = d;
    hs = !wv && lv;
    hold = m_run >= MW;
    e.lu_ready = hs;
    e.rw = wv ? wa != 0 : hs && la != 0;
    e.wa = wv ? wa : lv ? la : 5'd0;
    e.wd = wv ? wd : lv ? ld : 32'd0;
    e.hold = hold;
    e.err = m_err;
    e.hazard = haz(s1, hs, la) || haz(s2, hs, la) || haz(d, hs, la);
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_run = 0;
      m_err = 0;
    end else begin
      if ((wv && hold) || (iv && ir != 0 && m_busy[ir] && !(hs && la == ir)) || (hs && la != 0 && !m_busy[la]))
        m_err = 1;
      if (hs) m_busy[la] = 0;
      if (iv && ir != 0) m_busy[ir] = 1;
      m_run = (wv && lv) ? m_run + 1 : 0;
    end
    #1;
  endtask
  initial begin
    bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 10, 32'hA0 + i, 1, 3, 32'h55, 0, 0, 3, 0, 0);
    step(0, 0, 0, 0, 1, 3, 32'h55, 0, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 12, 32'hC0, 1, 3, 32'h77, 0, 0, 3, 7, 0);
    step(1, 0, 0, 0, 1, 3, 32'h77, 0, 0, 3, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 7);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    @(negedge clk); #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
